// File: rtl/blkmem_pkg.sv
// Shared types and helpers for the block-RAM read controller.
// State encodings, a constant-safe clog2 and the read-latency clamp.
package blkmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [2:0] clamp_lat(
        input logic [2:0] cfg,
        input int         max_lat
    );
        if (cfg == 3'd0) return 3'd1;
        if (int'(cfg) > max_lat) return 3'(max_lat);
        return cfg;
    endfunction

endpackage

// File: rtl/blkmem_rd_ctrl_if.sv
// Command, memory-port and response bundle of the read controller.
// master = command source / memory / consumer side, slave = controller.
interface blkmem_rd_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready,
        input  mem_en, mem_addr,
        output mem_rdata,
        input  rsp_valid, rsp_data, rsp_last,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready,
        output mem_en, mem_addr,
        input  mem_rdata,
        output rsp_valid, rsp_data, rsp_last,
        input  rsp_ready
    );
endinterface

// File: rtl/blkmem_rd_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// Head reads as zero while empty so outputs stay defined after reset.
module blkmem_rd_fifo
    import blkmem_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          dout,
    output logic                      empty,
    output logic [clog2(DEPTH+1)-1:0] count
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            unique case (1'b1)
                push && !pop: count <= count + CW'(1);
                !push && pop: count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rp];

endmodule

// File: rtl/blkmem_rd_ctrl.sv
// Burst read controller for synchronous-read block memories.
// Credit-limited issue, latency-tracking pipeline, show-ahead response FIFO.
module blkmem_rd_ctrl
    import blkmem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 8,
    parameter int MAX_LAT    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cfg_latency,
    output logic              busy,
    blkmem_rd_ctrl_if.slave   bus
);
    localparam int IW = clog2(MAX_LAT + 1);
    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam int SW = clog2(FIFO_DEPTH + MAX_LAT + 1);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [2:0]        lat_q;
    logic [IW-1:0]     inflight;
    logic [MAX_LAT-1:0] sr_v, sr_l;
    logic [MAX_LAT-1:0] sr_v_nxt, sr_l_nxt;

    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_dout;
    logic [SW-1:0]     occ;
    logic              accept, issue, emerge, pop, last_beat, done;

    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign accept    = bus.cmd_valid && bus.cmd_ready;
    // A same-cycle pop is deliberately not credited until the next cycle.
    assign occ       = SW'(inflight) + SW'(fifo_cnt);
    assign issue     = (state == ISSUE) && (occ < SW'(FIFO_DEPTH));
    assign last_beat = (rem_q == '0);
    assign emerge    = sr_v[0];
    assign pop       = !fifo_empty && bus.rsp_ready;
    assign done      = (inflight == '0) && (fifo_cnt == CW'(pop));

    assign bus.mem_en   = issue;
    assign bus.mem_addr = addr_q;
    assign busy         = (state != IDLE);

    // Enter at stage L-1 so the tag reaches stage 0 exactly L cycles later.
    always_comb begin
        sr_v_nxt = sr_v >> 1;
        sr_l_nxt = sr_l >> 1;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (issue && lat_q == 3'(i + 1)) begin
                sr_v_nxt[i] = 1'b1;
                sr_l_nxt[i] = last_beat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            lat_q    <= 3'd1;
            inflight <= '0;
            sr_v     <= '0;
            sr_l     <= '0;
        end else begin
            sr_v <= sr_v_nxt;
            sr_l <= sr_l_nxt;
            unique case (1'b1)
                issue && !emerge: inflight <= inflight + IW'(1);
                !issue && emerge: inflight <= inflight - IW'(1);
                default: ;
            endcase
            unique case (state)
                IDLE: if (accept) begin
                    addr_q <= bus.cmd_addr;
                    rem_q  <= bus.cmd_len;
                    lat_q  <= clamp_lat(cfg_latency, MAX_LAT);
                    state  <= ISSUE;
                end
                ISSUE: if (issue) begin
                    addr_q <= addr_q + 1'b1;
                    rem_q  <= rem_q - 1'b1;
                    if (last_beat) state <= DRAIN;
                end
                DRAIN: if (done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    blkmem_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (emerge),
        .din   ({sr_l[0], bus.mem_rdata}),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_data  = fifo_dout[DATA_W-1:0];
    assign bus.rsp_last  = fifo_dout[DATA_W];

endmodule

// File: tb/tb_blkmem_rd_ctrl.sv
// Directed bench for blkmem_rd_ctrl with a latency-accurate memory model
// and an address/response scoreboard.
module tb_blkmem_rd_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] cfg_latency;
    logic       busy;
    logic [2:0] mem_lat;
    int         total;
    int         bad;
    int         ens;

    logic [9:0]  addr_q[$];
    logic [32:0] exp_q[$];
    logic [10:0] mp [8];

    blkmem_rd_ctrl_if #(.ADDR_W(10), .DATA_W(32), .LEN_W(8)) bus ();

    blkmem_rd_ctrl #(
        .ADDR_W     (10),
        .DATA_W     (32),
        .LEN_W      (8),
        .MAX_LAT    (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_latency (cfg_latency),
        .busy        (busy),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [9:0] a);
        return {6'h2B, a, 6'h15, ~a};
    endfunction

    // Memory: data for a read issued in cycle t is on mem_rdata in cycle t+mem_lat.
    always @(posedge clk) begin
        mp[0] <= {bus.mem_en, bus.mem_addr};
        for (int j = 1; j < 8; j++) mp[j] <= mp[j-1];
    end
    assign bus.mem_rdata = (mp[mem_lat - 3'd1][10] === 1'b1)
                         ? data_of(mp[mem_lat - 3'd1][9:0]) : 32'hDEADBEEF;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.mem_en === 1'b1) begin
                if (addr_q.size() != 0)
                    chk("mem_addr", 64'(bus.mem_addr), 64'(addr_q.pop_front()));
                else
                    chk("en_unexp", 64'(bus.mem_en), 64'(0));
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                if (exp_q.size() != 0)
                    chk("rsp", 64'({bus.rsp_last, bus.rsp_data}),
                        64'(exp_q.pop_front()));
                else
                    chk("rsp_unexp", 64'(bus.rsp_valid), 64'(0));
            end
        end
    end

    task automatic send(input logic [9:0] addr, input int len,
                        input logic [2:0] cfg);
        logic [9:0] a;
        bit ok;
        for (int i = 0; i <= len; i++) begin
            a = addr + 10'(i);
            addr_q.push_back(a);
            exp_q.push_back({i == len, data_of(a)});
        end
        cfg_latency   = cfg;
        bus.cmd_addr  = addr;
        bus.cmd_len   = 8'(len);
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) chk("accept_to", 64'(bus.cmd_ready), 64'(1));
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Cycle-exact profile with rsp_ready held high; k counts cycles after accept.
    task automatic burst_timed(input string tag, input logic [9:0] addr,
                               input int len, input logic [2:0] cfg,
                               input int mlat, input int lx);
        int n;
        logic [3:0] e;
        mem_lat = 3'(mlat);
        n = len + 1;
        send(addr, len, cfg);
        for (int k = 1; k <= n + lx + 2; k++) begin
            @(negedge clk);
            e = {k <= n, (k >= lx + 2) && (k <= n + lx + 1),
                 k <= n + lx + 1, k > n + lx + 1};
            chk({tag, "_cyc"},
                64'({bus.mem_en, bus.rsp_valid, busy, bus.cmd_ready}), 64'(e));
            if (k == 1) begin
                @(posedge clk); #1;
                cfg_latency = ~cfg;
            end
        end
        chk({tag, "_sb"}, 64'(exp_q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy === 1'b0) ok = 1'b1;
        end
        if (!ok) chk(tag, 64'({busy, 16'(exp_q.size())}), 64'(0));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        cfg_latency   = 3'd1;
        mem_lat       = 3'd1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", 64'({bus.mem_en, bus.rsp_valid, bus.rsp_last,
                            busy, bus.cmd_ready}), 64'(0));
        chk("rst_addr", 64'(bus.mem_addr), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 64'({busy, bus.cmd_ready}), 64'(2'b01));
        @(posedge clk); #1;

        burst_timed("l1",   10'h010, 3, 3'd1, 1, 1);
        burst_timed("l4",   10'h123, 0, 3'd4, 4, 4);
        burst_timed("wrap", 10'h3FE, 3, 3'd2, 2, 2);
        burst_timed("cfg0", 10'h040, 2, 3'd0, 1, 1);
        burst_timed("cfg7", 10'h050, 5, 3'd7, 4, 4);

        // Full backpressure: only FIFO_DEPTH reads may be outstanding.
        mem_lat = 3'd3;
        bus.rsp_ready = 1'b0;
        send(10'h200, 20, 3'd3);
        ens = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.mem_en === 1'b1) ens++;
        end
        chk("bp_issues", 64'(ens), 64'(8));
        chk("bp_hold", 64'({bus.mem_en, bus.rsp_valid}), 64'(2'b01));
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_cyc", 64'(bus.mem_en), 64'(0));
        @(negedge clk);
        chk("bp_resume", 64'(bus.mem_en), 64'(1));
        wait_idle("bp_drain_to", 200);
        @(posedge clk); #1;

        // Reset with 3 reads in flight and 2 words buffered.
        bus.rsp_ready = 1'b0;
        send(10'h080, 10, 3'd3);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_rv", 64'(bus.rsp_valid), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        addr_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk("post_rst", 64'({bus.mem_en, bus.rsp_valid, busy, bus.cmd_ready}),
            64'(4'b0001));
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stale", 64'({bus.rsp_valid, bus.mem_en}), 64'(0));
        end
        @(posedge clk); #1;
        burst_timed("after_rst", 10'h1F0, 2, 3'd2, 2, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
